trace_render: RTL and testbench
===============================

Name: trace_render

Overview:
- Upstream feeder for tft_ctrl. Turns a captured logic-analyzer sample buffer into a sequence of rectangle draw commands: one full-screen background clear, then per-column level marks and transition edges for each channel.
- Reads samples from a synchronous capture RAM.
- Drives tft_ctrl's draw/busy handshake and its color/xstart/xend/ystart/yend inputs directly.

Parameters:
NCH, 4, number of channels (lanes) rendered
SAMPLES, 240, columns drawn; column x reads sample address x
ADDR_W, 8, capture RAM address width; must satisfy 2**ADDR_W >= SAMPLES
Y0, 20, top pixel row of lane 0
LANE_H, 40, vertical pitch between lanes in pixels
TRACE_H, 30, high-to-low trace distance in pixels
BG_COLOR, 16'h0000, RGB565 background
HI_COLOR, 16'h07E0, RGB565 high-level mark
LO_COLOR, 16'hF800, RGB565 low-level mark
EDGE_COLOR, 16'hFFFF, RGB565 transition edge

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a frame render when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last command has completed
rd_addr  out  ADDR_W  capture RAM read address
rd_data  in  NCH  capture RAM data; valid exactly 1 cycle after rd_addr
draw  out  1  draw request to tft_ctrl
tft_busy  in  1  busy from tft_ctrl
color  out  16  RGB565 fill colour
xstart  out  16  rectangle left column, inclusive
xend  out  16  rectangle right column, inclusive
ystart  out  16  rectangle top row, inclusive
yend  out  16  rectangle bottom row, inclusive

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: draw=0, busy=0, done=0, rd_addr=0, color/x*/y* all 0, FSM=IDLE.
- Main FSM states:
  - IDLE: start=1 → SYNC. start is ignored in every other state.
  - SYNC: wait until tft_busy=0, which covers a tft_ctrl init in progress → CLEAR.
  - CLEAR: load command {BG_COLOR, x 0..239, y 0..319} and issue it → FETCH with x=0.
  - FETCH: drive rd_addr=x → LATCH (1 cycle).
  - LATCH: cur<=rd_data; prev<=cur, except at x=0 where prev<=rd_data; ch=0 → LEVEL.
  - LEVEL: ybase=Y0+ch*LANE_H; y=ybase if cur[ch] else ybase+TRACE_H.
    - Issue {HI_COLOR or LO_COLOR, x..x, y..y}.
    - Then → EDGE if x>0 and cur[ch]!=prev[ch], else → NEXTCH.
  - EDGE: issue {EDGE_COLOR, x..x, ybase..ybase+TRACE_H} → NEXTCH.
  - NEXTCH: if ch==NCH-1, → NEXTX; else ch+1 → LEVEL.
  - NEXTX: if x==SAMPLES-1, → FIN; else x+1 → FETCH.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- Command order is fixed: clear; then for each x, for each ch: level, then edge if present.
- Issue handshake (all commands):
  - Present cmd and assert draw=1 in the same cycle. Hold cmd and draw stable until tft_busy is sampled 1.
  - Next cycle draw=0; cmd stays held until tft_busy is sampled 0, then the issue completes.
  - Issue never starts while tft_busy=1.
- Arithmetic: all coordinates are 16-bit unsigned. x is zero-extended. Products and sums wrap modulo 2^16 with no saturation; parameter choice must keep values on-screen.
- Boundaries:
  - SAMPLES=1: no edge commands are issued.
  - A tft_busy pulse arriving in the same cycle draw rises is accepted.
  - done and start in the same cycle: start is ignored, because the FSM is not yet IDLE.
- Reset mid-frame: outputs return to reset values immediately; tft_ctrl may finish its current rectangle. A later start re-enters through SYNC, so no command is issued while tft_busy=1.
- Throughput: rendering is handshake-bound. There is 1 extra RAM-latency cycle per column.

Decomposition:
- Shared package (draw_pkg):
  - RGB565 colour constants.
  - Screen size constants 240/320.
  - Packed draw-command type {color, xstart, xend, ystart, yend}, 80 bits, in that field order.
- Sub-module tft_cmd_issue: owns the draw/busy handshake. Takes an 80-bit cmd plus a go pulse; returns an ack when complete. Reusable by the other tft_ctrl clients.

Test Plan:
All scenarios use NCH=2, SAMPLES=4, default Y0/LANE_H/TRACE_H.
1. ch0 samples 0,1,1,0 and ch1 samples 1,1,1,1; tft_busy model rises 2 cycles after draw and falls 5 cycles later.
   - Exactly 11 commands.
   - First: {0000, 0..239, 0..319}.
   - x=0: ch0 {F800, 0..0, 50..50}, then ch1 {07E0, 0..0, 60..60}.
   - x=1: ch0 level {07E0, 1..1, 20..20}, then edge {FFFF, 1..1, 20..50}.
   - Single done pulse.
2. Hold tft_busy=1 for 100 cycles after start → draw stays 0 throughout; first draw occurs the cycle after tft_busy falls.
3. Constant samples on both channels → 9 commands, no EDGE_COLOR command.
4. Assert rst for 1 cycle while draw=1 on the 5th command → draw, busy, done go to 0 asynchronously. A re-start then yields the full 11-command sequence again, beginning with the clear.
5. Pulse start while busy=1 → ignored; command count unchanged; exactly one done.
6. Every issue: cmd is stable from draw rise until tft_busy falls; draw is never high while tft_busy was high in the prior cycle outside an accepted issue.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for tft_ctrl draw clients: colours, screen size, the
// 80-bit rectangle command and the state encodings of its producers.
package draw_pkg;

  localparam logic [15:0] SCREEN_W  = 16'd240;
  localparam logic [15:0] SCREEN_H  = 16'd320;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;

  typedef struct packed {
    logic [15:0] color;
    logic [15:0] xstart;
    logic [15:0] xend;
    logic [15:0] ystart;
    logic [15:0] yend;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    IS_IDLE = 2'd0,
    IS_PEND = 2'd1,
    IS_REQ  = 2'd2,
    IS_WAIT = 2'd3
  } issue_state_t;

  typedef enum logic [3:0] {
    TR_IDLE   = 4'd0,
    TR_SYNC   = 4'd1,
    TR_CLEAR  = 4'd2,
    TR_FETCH  = 4'd3,
    TR_LATCH  = 4'd4,
    TR_LEVEL  = 4'd5,
    TR_EDGE   = 4'd6,
    TR_NEXTCH = 4'd7,
    TR_NEXTX  = 4'd8,
    TR_FIN    = 4'd9
  } tr_state_t;

  function automatic draw_cmd_t mk_cmd(input logic [15:0] c,
                                       input logic [15:0] x0,
                                       input logic [15:0] x1,
                                       input logic [15:0] y0,
                                       input logic [15:0] y1);
    draw_cmd_t r;
    r.color  = c;
    r.xstart = x0;
    r.xend   = x1;
    r.ystart = y0;
    r.yend   = y1;
    return r;
  endfunction

endpackage

// File: rtl/tft_cmd_issue.sv
// Issues one rectangle command to tft_ctrl over its draw/busy handshake and
// pulses ack once tft_ctrl has accepted and finished it.
module tft_cmd_issue
  import draw_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      go_i,
  input  draw_cmd_t cmd_i,
  input  logic      tft_busy_i,
  output logic      draw_o,
  output draw_cmd_t cmd_o,
  output logic      ack_o
);

  issue_state_t state_q, state_d;
  logic         draw_q, draw_d;
  logic         ack_q, ack_d;
  draw_cmd_t    cmd_q, cmd_d;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IS_IDLE;
      draw_q  <= 1'b0;
      ack_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      draw_q  <= draw_d;
      ack_q   <= ack_d;
      cmd_q   <= cmd_d;
    end
  end

  // A request only rises after tft_busy was seen low, so an in-flight
  // rectangle from another client or a pre-reset frame is never stomped.
  always_comb begin
    state_d = state_q;
    draw_d  = draw_q;
    cmd_d   = cmd_q;
    ack_d   = 1'b0;
    case (state_q)
      IS_IDLE: begin
        if (go_i) begin
          cmd_d = cmd_i;
          if (!tft_busy_i) begin
            draw_d  = 1'b1;
            state_d = IS_REQ;
          end else begin
            state_d = IS_PEND;
          end
        end else begin
          state_d = IS_IDLE;
        end
      end
      IS_PEND: begin
        if (!tft_busy_i) begin
          draw_d  = 1'b1;
          state_d = IS_REQ;
        end else begin
          state_d = IS_PEND;
        end
      end
      IS_REQ: begin
        if (tft_busy_i) begin
          draw_d  = 1'b0;
          state_d = IS_WAIT;
        end else begin
          state_d = IS_REQ;
        end
      end
      IS_WAIT: begin
        if (!tft_busy_i) begin
          ack_d   = 1'b1;
          state_d = IS_IDLE;
        end else begin
          state_d = IS_WAIT;
        end
      end
      default: begin
        draw_d  = 1'b0;
        state_d = IS_IDLE;
      end
    endcase
  end

  assign draw_o = draw_q;
  assign cmd_o  = cmd_q;
  assign ack_o  = ack_q;

endmodule

// File: rtl/trace_render.sv
// Renders a captured logic-analyzer buffer as tft_ctrl rectangles: a full
// screen clear, then per column a level mark per lane plus transition edges.
module trace_render
  import draw_pkg::*;
#(
  parameter int          NCH        = 4,
  parameter int          SAMPLES    = 240,
  parameter int          ADDR_W     = 8,
  parameter int          Y0         = 20,
  parameter int          LANE_H     = 40,
  parameter int          TRACE_H    = 30,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter logic [15:0] HI_COLOR   = 16'h07E0,
  parameter logic [15:0] LO_COLOR   = 16'hF800,
  parameter logic [15:0] EDGE_COLOR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [NCH-1:0]    rd_data,
  output logic              draw,
  input  logic              tft_busy,
  output logic [15:0]       color,
  output logic [15:0]       xstart,
  output logic [15:0]       xend,
  output logic [15:0]       ystart,
  output logic [15:0]       yend
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  tr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NCH-1:0]    cur_q, cur_d;
  logic [NCH-1:0]    prev_q, prev_d;
  logic              issued_q, issued_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              go_s;
  logic              ack_s;
  draw_cmd_t         cmd_s;
  draw_cmd_t         iss_cmd_s;
  logic [15:0]       x16_s;
  logic [15:0]       ybase_s;
  logic [15:0]       ybot_s;
  logic              lvl_s;
  logic              edge_s;

  // Lane geometry for the current column/channel; wraps modulo 2^16.
  always_comb begin
    x16_s   = 16'(x_q);
    ybase_s = 16'(Y0 + LANE_H * int'(ch_q));
    ybot_s  = ybase_s + 16'(TRACE_H);
    lvl_s   = cur_q[ch_q];
    edge_s  = (x_q != {ADDR_W{1'b0}}) && (cur_q[ch_q] != prev_q[ch_q]);
  end

  // Main sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TR_IDLE;
      x_q      <= {ADDR_W{1'b0}};
      ch_q     <= {CH_W{1'b0}};
      cur_q    <= {NCH{1'b0}};
      prev_q   <= {NCH{1'b0}};
      issued_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      ch_q     <= ch_d;
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      issued_q <= issued_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. Command states pulse go once, then wait for ack.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    ch_d     = ch_q;
    cur_d    = cur_q;
    prev_d   = prev_q;
    issued_d = issued_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    go_s     = 1'b0;
    cmd_s    = mk_cmd(BG_COLOR, 16'd0, SCREEN_W - 16'd1, 16'd0, SCREEN_H - 16'd1);
    case (state_q)
      TR_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          state_d = TR_SYNC;
        end else begin
          state_d = TR_IDLE;
        end
      end
      // Launch the clear directly so the first draw follows tft_busy falling.
      TR_SYNC: begin
        if (!tft_busy) begin
          go_s    = 1'b1;
          state_d = TR_CLEAR;
        end else begin
          state_d = TR_SYNC;
        end
      end
      TR_CLEAR: begin
        if (ack_s) begin
          x_d     = {ADDR_W{1'b0}};
          state_d = TR_FETCH;
        end else begin
          state_d = TR_CLEAR;
        end
      end
      TR_FETCH: begin
        state_d = TR_LATCH;
      end
      TR_LATCH: begin
        cur_d    = rd_data;
        prev_d   = (x_q == {ADDR_W{1'b0}}) ? rd_data : cur_q;
        ch_d     = {CH_W{1'b0}};
        issued_d = 1'b0;
        state_d  = TR_LEVEL;
      end
      TR_LEVEL: begin
        cmd_s = mk_cmd(lvl_s ? HI_COLOR : LO_COLOR, x16_s, x16_s,
                       lvl_s ? ybase_s : ybot_s, lvl_s ? ybase_s : ybot_s);
        if (!issued_q) begin
          go_s     = 1'b1;
          issued_d = 1'b1;
        end else if (ack_s) begin
          issued_d = 1'b0;
          state_d  = edge_s ? TR_EDGE : TR_NEXTCH;
        end else begin
          state_d = TR_LEVEL;
        end
      end
      TR_EDGE: begin
        cmd_s = mk_cmd(EDGE_COLOR, x16_s, x16_s, ybase_s, ybot_s);
        if (!issued_q) begin
          go_s     = 1'b1;
          issued_d = 1'b1;
        end else if (ack_s) begin
          issued_d = 1'b0;
          state_d  = TR_NEXTCH;
        end else begin
          state_d = TR_EDGE;
        end
      end
      TR_NEXTCH: begin
        if (ch_q == CH_W'(NCH - 1)) begin
          state_d = TR_NEXTX;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = TR_LEVEL;
        end
      end
      // done rises together with entering FIN, so a start in that cycle is ignored.
      TR_NEXTX: begin
        if (x_q == ADDR_W'(SAMPLES - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = TR_FIN;
        end else begin
          x_d     = x_q + ADDR_W'(1);
          state_d = TR_FETCH;
        end
      end
      TR_FIN: begin
        state_d = TR_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = TR_IDLE;
      end
    endcase
  end

  tft_cmd_issue u_issue (
    .clk        (clk),
    .rst        (rst),
    .go_i       (go_s),
    .cmd_i      (cmd_s),
    .tft_busy_i (tft_busy),
    .draw_o     (draw),
    .cmd_o      (iss_cmd_s),
    .ack_o      (ack_s)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_addr = x_q;
  assign color   = iss_cmd_s.color;
  assign xstart  = iss_cmd_s.xstart;
  assign xend    = iss_cmd_s.xend;
  assign ystart  = iss_cmd_s.ystart;
  assign yend    = iss_cmd_s.yend;

endmodule

// File: tb/tb_trace_render.sv
// Directed bench for trace_render with a tft_ctrl busy model, a capture RAM
// model and a command scoreboard built from the sample table.
module tb_trace_render;
  import draw_pkg::*;

  localparam int NCH     = 2;
  localparam int SAMPLES = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [7:0]      rd_addr;
  logic [NCH-1:0]  rd_data = '0;
  logic            draw;
  logic            tft_busy;
  logic [15:0]     color, xstart, xend, ystart, yend;

  logic            force_busy;
  logic            model_busy = 1'b0;
  int              bcnt = 0;
  logic [NCH-1:0]  mem [SAMPLES];

  draw_cmd_t       exp_q [$];
  draw_cmd_t       got_q [$];
  int              n_vec;
  int              n_mis;

  draw_cmd_t       mon_cmd;
  draw_cmd_t       held;
  logic            d_prev = 1'b0;
  logic            b_prev = 1'b0;
  bit              in_issue = 1'b0;
  bit              seen_b = 1'b0;
  int              viol = 0;

  trace_render #(.NCH(NCH), .SAMPLES(SAMPLES)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .draw(draw), .tft_busy(tft_busy),
    .color(color), .xstart(xstart), .xend(xend), .ystart(ystart), .yend(yend)
  );

  always #5 clk = ~clk;

  assign tft_busy = model_busy | force_busy;

  always @(posedge clk) rd_data <= mem[rd_addr[1:0]];

  // tft_ctrl model: busy rises 2 cycles after seeing draw, stays 5 cycles.
  always @(posedge clk) begin
    if (bcnt == 0) begin
      if (draw) bcnt <= 1;
    end else begin
      if (bcnt == 2) model_busy <= 1'b1;
      if (bcnt == 7) begin
        model_busy <= 1'b0;
        bcnt <= 0;
      end else begin
        bcnt <= bcnt + 1;
      end
    end
  end

  // Captures commands on draw rise and watches handshake/stability rules.
  always @(posedge clk) begin
    mon_cmd = '{color, xstart, xend, ystart, yend};
    if (rst) begin
      in_issue = 1'b0;
      seen_b   = 1'b0;
    end else begin
      if (draw && !d_prev) begin
        got_q.push_back(mon_cmd);
        held     = mon_cmd;
        in_issue = 1'b1;
        seen_b   = 1'b0;
        if (b_prev) viol++;
      end else if (in_issue && mon_cmd !== held) begin
        viol++;
      end
      if (in_issue && tft_busy) seen_b = 1'b1;
      else if (in_issue && seen_b && !tft_busy) in_issue = 1'b0;
    end
    d_prev = rst ? 1'b0 : draw;
    b_prev = tft_busy;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_samples(input logic [3:0] c0, input logic [3:0] c1);
    for (int x = 0; x < SAMPLES; x++) mem[x] = {c1[x], c0[x]};
  endtask

  task automatic build_exp();
    logic        b;
    logic [15:0] yb;
    logic [15:0] yl;
    exp_q.delete();
    exp_q.push_back('{16'h0000, 16'd0, 16'd239, 16'd0, 16'd319});
    for (int x = 0; x < SAMPLES; x++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        b  = mem[x][ch];
        yb = 16'(20 + 40 * ch);
        yl = b ? yb : yb + 16'd30;
        exp_q.push_back('{b ? 16'h07E0 : 16'hF800, 16'(x), 16'(x), yl, yl});
        if (x > 0 && b != mem[x-1][ch])
          exp_q.push_back('{16'hFFFF, 16'(x), 16'(x), yb, yb + 16'd30});
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_count"}, 80'(got_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit overlap, input bit at_done);
    int nd;
    int after;
    nd = 0;
    after = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (overlap && i == 40) begin
        chk("busy_mid_frame", 80'(busy), 80'(1));
        start = 1'b1;
      end
      if (done) begin
        nd++;
        if (nd == 1 && at_done) start = 1'b1;
      end
      if (nd > 0) after++;
      if (after > 20) break;
    end
    start = 1'b0;
    chk("done_pulses", 80'(nd), 80'(1));
    chk("busy_after_done", 80'(busy), 80'(0));
  endtask

  initial begin
    int draws;
    int nedge;
    rst = 1'b1;
    start = 1'b0;
    force_busy = 1'b0;
    n_vec = 0;
    n_mis = 0;
    set_samples(4'b0110, 4'b1111);
    repeat (3) @(negedge clk);
    chk("rst_draw", 80'(draw), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_rd_addr", 80'(rd_addr), 80'(0));
    chk("rst_cmd", {color, xstart, xend, ystart, yend}, 80'(0));
    rst = 1'b0;
    @(negedge clk);

    // Scenario: mixed samples, 11 commands, single done.
    build_exp();
    got_q.delete();
    pulse_start();
    wait_done(1'b0, 1'b0);
    compare_frame("s1");

    // Scenario: start while busy and start coinciding with done are ignored.
    got_q.delete();
    pulse_start();
    wait_done(1'b1, 1'b1);
    compare_frame("s5");

    // Scenario: constant samples give no edge commands.
    set_samples(4'b1111, 4'b0000);
    build_exp();
    got_q.delete();
    pulse_start();
    wait_done(1'b0, 1'b0);
    compare_frame("s3");
    nedge = 0;
    foreach (got_q[i]) if (got_q[i].color == 16'hFFFF) nedge++;
    chk("s3_edge_cmds", 80'(nedge), 80'(0));

    // Scenario: tft_busy held high after start blocks the first draw.
    set_samples(4'b0110, 4'b1111);
    build_exp();
    got_q.delete();
    force_busy = 1'b1;
    pulse_start();
    draws = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (draw) draws++;
    end
    chk("held_busy_draws", 80'(draws), 80'(0));
    force_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("draw_after_release", 80'(draw), 80'(1));
    wait_done(1'b0, 1'b0);
    compare_frame("s2");

    // Scenario: reset during the 5th command, then a clean re-render.
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 3000 && got_q.size() < 5; i++) @(negedge clk);
    chk("reached_cmd5", 80'(got_q.size() >= 5), 80'(1));
    chk("draw_before_rst", 80'(draw), 80'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_draw", 80'(draw), 80'(0));
    chk("async_rst_busy", 80'(busy), 80'(0));
    chk("async_rst_done", 80'(done), 80'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    got_q.delete();
    pulse_start();
    wait_done(1'b0, 1'b0);
    compare_frame("s4");

    chk("handshake_violations", 80'(viol), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
